// File: rtl/result_checker.sv
// Result checker: compares a stream of DUT samples against a small expected RAM.
// It discards a fixed number of leading samples, then counts mismatches and records where the first one was.
module result_checker #(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 5,
  parameter int SKIP        = 8,
  parameter int STOP_ON_ERR = 0,
  localparam int IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              exp_we,
  input  logic [IDX_W-1:0]  exp_addr,
  input  logic [DATA_W-1:0] exp_wdata,
  input  logic              start,
  input  logic              dut_valid,
  input  logic [DATA_W-1:0] dut_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  err_count,
  output logic              first_err_valid,
  output logic [IDX_W-1:0]  first_err_idx,
  output logic [IDX_W-1:0]  check_idx
);

  localparam int SKIP_W = (SKIP > 0) ? $clog2(SKIP + 1) : 1;
  localparam int SKIP_LAST_I = (SKIP > 0) ? SKIP - 1 : 0;
  localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'(SKIP_LAST_I);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W:0]    DEPTH_X   = (IDX_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0]  MAX_ERR   = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, SKIPPING, CHECK, FINISHED} state_t;

  state_t             state_q;
  logic               busy_q, done_q, pass_q;
  logic [CNT_W-1:0]   err_count_q;
  logic               first_err_valid_q;
  logic [IDX_W-1:0]   first_err_idx_q;
  logic [IDX_W-1:0]   check_idx_q;
  logic [SKIP_W-1:0]  skip_cnt_q;
  logic [DATA_W-1:0]  exp_mem [DEPTH];

  logic               ramWritable;
  logic               mismatch;
  logic               lastCompare;
  logic               finishRun;
  logic [CNT_W-1:0]   err_count_d;
  logic [IDX_W-1:0]   check_idx_d;

  assign ramWritable = (state_q == IDLE) || (state_q == FINISHED);
  assign mismatch    = (dut_data != exp_mem[check_idx_q]);
  assign lastCompare = (check_idx_q == LAST_IDX);
  assign finishRun   = lastCompare || ((STOP_ON_ERR != 0) && mismatch);
  assign err_count_d = (mismatch && (err_count_q != MAX_ERR)) ? err_count_q + 1'b1 : err_count_q;
  // The index never wraps: the final compare (or a stop-on-error at the top) leaves it at DEPTH-1.
  assign check_idx_d = lastCompare ? check_idx_q : check_idx_q + 1'b1;

  // Expected RAM has no reset so that aborting a run keeps the loaded vectors.
  always_ff @(posedge clk) begin
    if (!reset && exp_we && ramWritable && ({1'b0, exp_addr} < DEPTH_X)) begin
      exp_mem[exp_addr] <= exp_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= IDLE;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
      pass_q            <= 1'b0;
      err_count_q       <= '0;
      first_err_valid_q <= 1'b0;
      first_err_idx_q   <= '0;
      check_idx_q       <= '0;
      skip_cnt_q        <= '0;
    end else begin
      case (state_q)
        IDLE, FINISHED: begin
          if (start) begin
            state_q           <= (SKIP == 0) ? CHECK : SKIPPING;
            busy_q            <= 1'b1;
            done_q            <= 1'b0;
            pass_q            <= 1'b0;
            err_count_q       <= '0;
            first_err_valid_q <= 1'b0;
            first_err_idx_q   <= '0;
            check_idx_q       <= '0;
            skip_cnt_q        <= '0;
          end
        end
        SKIPPING: begin
          if (dut_valid) begin
            skip_cnt_q <= skip_cnt_q + 1'b1;
            if (skip_cnt_q == SKIP_LAST) begin
              state_q <= CHECK;
            end
          end
        end
        CHECK: begin
          if (dut_valid) begin
            err_count_q <= err_count_d;
            check_idx_q <= check_idx_d;
            if (mismatch && !first_err_valid_q) begin
              first_err_valid_q <= 1'b1;
              first_err_idx_q   <= check_idx_q;
            end
            if (finishRun) begin
              state_q <= FINISHED;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_count_d == '0);
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          pass_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_count       = err_count_q;
  assign first_err_valid = first_err_valid_q;
  assign first_err_idx   = first_err_idx_q;
  assign check_idx       = check_idx_q;

endmodule

// File: tb/tb_result_checker.sv
// Directed bench for result_checker: a default instance plus a STOP_ON_ERR=1 instance sharing the same stimulus.
module tb_result_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic       exp_we;
  logic [2:0] exp_addr;
  logic [7:0] exp_wdata;
  logic       start;
  logic       dut_valid;
  logic [7:0] dut_data;

  logic       busy, done, pass, fev;
  logic [2:0] errCount, fei, idx;
  logic       sBusy, sDone, sPass, sFev;
  logic [2:0] sErrCount, sFei, sIdx;

  int vectors = 0;
  int miscompares = 0;

  result_checker dut (
    .clk(clk), .reset(reset), .exp_we(exp_we), .exp_addr(exp_addr), .exp_wdata(exp_wdata),
    .start(start), .dut_valid(dut_valid), .dut_data(dut_data),
    .busy(busy), .done(done), .pass(pass), .err_count(errCount),
    .first_err_valid(fev), .first_err_idx(fei), .check_idx(idx)
  );

  result_checker #(.STOP_ON_ERR(1)) dutStop (
    .clk(clk), .reset(reset), .exp_we(exp_we), .exp_addr(exp_addr), .exp_wdata(exp_wdata),
    .start(start), .dut_valid(dut_valid), .dut_data(dut_data),
    .busy(sBusy), .done(sDone), .pass(sPass), .err_count(sErrCount),
    .first_err_valid(sFev), .first_err_idx(sFei), .check_idx(sIdx)
  );

  always #5 clk = ~clk;

  // One clock with the given sample driven; outputs are then sampled 1ns after the edge.
  task automatic applyStimulus(input logic v, input logic [7:0] d);
    dut_valid = v;
    dut_data  = d;
    @(posedge clk);
    #1;
    dut_valid = 1'b0;
    start     = 1'b0;
    exp_we    = 1'b0;
    reset     = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic startRun();
    start = 1'b1;
    applyStimulus(1'b0, 8'h00);
  endtask

  task automatic junkSamples();
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'hE0 + 8'(i));
  endtask

  logic [7:0] good [5] = '{8'd1, 8'd1, 8'd2, 8'd3, 8'd5};

  initial begin
    reset = 1'b1; exp_we = 1'b0; exp_addr = '0; exp_wdata = '0;
    start = 1'b0; dut_valid = 1'b0; dut_data = '0;
    @(posedge clk); #1;
    reset = 1'b1;
    applyStimulus(1'b0, 8'h00);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset pass", pass, 0);
    checkOutput("reset err_count", errCount, 0);
    checkOutput("reset first_err_valid", fev, 0);
    checkOutput("reset check_idx", idx, 0);

    for (int i = 0; i < 5; i++) begin
      exp_we = 1'b1; exp_addr = 3'(i); exp_wdata = good[i];
      applyStimulus(1'b0, 8'h00);
    end

    // Clean run
    startRun();
    checkOutput("clean busy after start", busy, 1);
    junkSamples();
    checkOutput("clean idx after skip", idx, 0);
    checkOutput("clean busy after skip", busy, 1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, good[i]);
    checkOutput("clean done", done, 1);
    checkOutput("clean pass", pass, 1);
    checkOutput("clean err_count", errCount, 0);
    checkOutput("clean first_err_valid", fev, 0);
    checkOutput("clean busy", busy, 0);
    checkOutput("clean check_idx", idx, 4);

    // Third compare wrong
    startRun();
    junkSamples();
    applyStimulus(1'b1, 8'd1);
    applyStimulus(1'b1, 8'd1);
    applyStimulus(1'b1, 8'd7);
    checkOutput("bad3 err_count after compare", errCount, 1);
    checkOutput("bad3 first_err_idx after compare", fei, 2);
    checkOutput("bad3 first_err_valid", fev, 1);
    checkOutput("stop bad3 done", sDone, 1);
    checkOutput("stop bad3 check_idx", sIdx, 3);
    applyStimulus(1'b1, 8'd3);
    checkOutput("bad3 not done after 4th", done, 0);
    applyStimulus(1'b1, 8'd5);
    checkOutput("bad3 done", done, 1);
    checkOutput("bad3 pass", pass, 0);
    checkOutput("bad3 err_count", errCount, 1);
    checkOutput("stop bad3 err_count frozen", sErrCount, 1);

    // Mismatches at 1 and 4, with an attempted RAM write during CHECK
    startRun();
    junkSamples();
    exp_we = 1'b1; exp_addr = 3'd0; exp_wdata = 8'd99;
    applyStimulus(1'b1, 8'd1);
    applyStimulus(1'b1, 8'd0);
    applyStimulus(1'b1, 8'd2);
    applyStimulus(1'b1, 8'd3);
    applyStimulus(1'b1, 8'd0);
    checkOutput("two err_count", errCount, 2);
    checkOutput("two first_err_idx", fei, 1);
    checkOutput("two done", done, 1);

    // Valid toggling with start pulses while busy
    startRun();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 8'hF0);
      if (i == 3) start = 1'b1;
      applyStimulus(1'b0, 8'h01);
    end
    checkOutput("toggle busy after skip", busy, 1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, good[i]);
      if (i == 1) begin
        start = 1'b1;
        applyStimulus(1'b0, 8'h77);
        checkOutput("toggle idx held on idle cycle", idx, 2);
        checkOutput("toggle start ignored", busy, 1);
      end else begin
        applyStimulus(1'b0, 8'h77);
      end
    end
    checkOutput("toggle done", done, 1);
    checkOutput("toggle pass (RAM unchanged)", pass, 1);
    checkOutput("toggle err_count", errCount, 0);
    checkOutput("toggle first_err_valid", fev, 0);

    // Stop-on-error instance, mismatch at index 3
    startRun();
    junkSamples();
    applyStimulus(1'b1, 8'd1);
    applyStimulus(1'b1, 8'd1);
    applyStimulus(1'b1, 8'd2);
    applyStimulus(1'b1, 8'd9);
    checkOutput("stop done at 4th", sDone, 1);
    checkOutput("stop err_count", sErrCount, 1);
    checkOutput("stop first_err_idx", sFei, 3);
    checkOutput("stop check_idx", sIdx, 4);
    checkOutput("stop pass", sPass, 0);
    applyStimulus(1'b1, 8'd5);
    applyStimulus(1'b1, 8'd6);
    checkOutput("stop no further counting", sErrCount, 1);
    checkOutput("stop idx frozen", sIdx, 4);
    checkOutput("default err_count idx3 run", errCount, 1);
    checkOutput("default first_err_idx idx3 run", fei, 3);

    // Reset mid-run, then rerun without reloading RAM
    startRun();
    junkSamples();
    applyStimulus(1'b1, 8'd1);
    applyStimulus(1'b1, 8'd1);
    checkOutput("abort idx before reset", idx, 2);
    reset = 1'b1;
    applyStimulus(1'b0, 8'h00);
    checkOutput("abort busy", busy, 0);
    checkOutput("abort done", done, 0);
    checkOutput("abort check_idx", idx, 0);
    checkOutput("abort err_count", errCount, 0);
    startRun();
    junkSamples();
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, good[i]);
    checkOutput("rerun pass", pass, 1);
    checkOutput("rerun done", done, 1);
    checkOutput("rerun stop pass", sPass, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/result_checker.md
RESULT_CHECKER -- requirements
Module: result_checker

Interface
REQ-001 Parameter DATA_W, default 8: width of each checked data word.
REQ-002 Parameter DEPTH, default 5: number of expected words and the number of compares per run.
REQ-003 Parameter SKIP, default 8: number of dut_valid samples discarded before comparing starts.
REQ-004 Parameter STOP_ON_ERR, default 0: when 1, the run ends on the first mismatch.
REQ-005 Derived widths SHALL be IDX_W = max(1, clog2(DEPTH)) and CNT_W = clog2(DEPTH+1).
REQ-006 clk  in  1  clock; all state changes on the rising edge.
REQ-007 reset  in  1  reset, synchronous, active-high.
REQ-008 exp_we  in  1  expected-RAM write enable.
REQ-009 exp_addr  in  IDX_W  expected-RAM write address.
REQ-010 exp_wdata  in  DATA_W  expected-RAM write data.
REQ-011 start  in  1  one-cycle run request.
REQ-012 dut_valid  in  1  dut_data is a sample this cycle.
REQ-013 dut_data  in  DATA_W  observed data word.
REQ-014 busy  out  1  high in SKIP or CHECK.
REQ-015 done  out  1  high in DONE.
REQ-016 pass  out  1  high in DONE when err_count == 0.
REQ-017 err_count  out  CNT_W  mismatches in the current or last run.
REQ-018 first_err_valid  out  1  at least one mismatch has been captured.
REQ-019 first_err_idx  out  IDX_W  compare index of the first mismatch.
REQ-020 check_idx  out  IDX_W  index of the next expected word to compare.

Function
REQ-021 The block SHALL hold a DEPTH x DATA_W expected RAM, written on a clock edge with exp_we=1 only in IDLE or DONE; writes in other states, or with exp_addr >= DEPTH, SHALL be ignored.
REQ-022 The FSM SHALL have the states IDLE, SKIP, CHECK and DONE, with every output registered.
REQ-023 In IDLE or DONE, start=1 SHALL clear err_count, check_idx, first_err_valid, first_err_idx and the skip counter, then enter SKIP (or CHECK directly if SKIP == 0).
REQ-024 start in SKIP or CHECK SHALL be ignored.
REQ-025 In SKIP, each dut_valid=1 cycle SHALL increment the skip counter; the block SHALL enter CHECK on the edge that accepts the SKIP-th sample.
REQ-026 In CHECK, each dut_valid=1 cycle SHALL compare dut_data with exp[check_idx] and increment check_idx.
REQ-027 On a mismatch, err_count SHALL increment; if first_err_valid=0, the block SHALL set first_err_valid=1 and capture first_err_idx = check_idx.
REQ-028 The outputs for a compare SHALL be visible one cycle after the sampling edge.
REQ-029 dut_valid=0 cycles SHALL change no state in any state.
REQ-030 The block SHALL enter DONE on the edge that performs the DEPTH-th compare; check_idx SHALL then hold DEPTH-1 and not wrap.
REQ-031 With STOP_ON_ERR=1, the block SHALL enter DONE on the edge of the first mismatch, and check_idx SHALL freeze at the mismatching index plus 1, saturating at DEPTH-1.
REQ-032 err_count SHALL NOT exceed DEPTH.
REQ-033 DONE SHALL persist until start or reset; pass SHALL be 1 only in DONE with err_count == 0.
REQ-034 If start and exp_we are both high in IDLE on the same edge, both SHALL take effect, and a compare at that address SHALL use the newly written value.

Reset
REQ-035 On reset, the block SHALL enter IDLE with busy=0, done=0, pass=0, err_count=0, first_err_valid=0, first_err_idx=0, check_idx=0 and the skip counter at 0.
REQ-036 Reset asserted mid-run SHALL abort the run with the values of REQ-035 and SHALL NOT alter the expected RAM contents.

Verification
REQ-037 Defaults, exp = {1,1,2,3,5}, start, 8 junk samples then 1,1,2,3,5 -> done=1, pass=1, err_count=0, first_err_valid=0.
REQ-038 Same stimulus but the third compared sample is 7 -> err_count=1, first_err_idx=2, pass=0, done after the 5th compare.
REQ-039 Mismatches at compare indices 1 and 4 -> err_count=2, first_err_idx=1; exp_we during CHECK leaves the RAM unchanged.
REQ-040 STOP_ON_ERR=1, mismatch at index 3 -> done one cycle after the 4th sample edge, err_count=1, first_err_idx=3, and no further samples counted.
REQ-041 dut_valid toggled 1/0 through SKIP and CHECK -> results identical to REQ-037; start pulsed while busy -> ignored.
REQ-042 Reset asserted after 2 compares -> all outputs 0 and IDLE next cycle; a rerun of REQ-037 without rewriting the RAM -> pass=1.
